// File: rtl/seg_scan_mux.sv
// Time-multiplexed scanner for a 4-digit 7-segment display.
// Walks the digits at a fixed prescaled rate; new data is committed only at a frame boundary.
module seg_scan_mux #(
    parameter int unsigned TICK_DIV = 16,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] din,
    output logic        load_ack,
    output logic [3:0]  bcd,
    output logic [3:0]  an,
    output logic        blank,
    output logic        frame_done
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned DATA_W = 16;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(3);

    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [IDX_W-1:0]  idx_q,       idx_d;
    logic [DATA_W-1:0] disp_q,      disp_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic              pend_q,      pend_d;
    logic              frame_done_q, frame_done_d;
    logic [DIG_W-1:0]  bcd_q,       bcd_d;
    logic [3:0]        an_q,        an_d;
    logic              blank_q,     blank_d;
    logic              tick_c;

    // Nibble of the given digit index.
    function automatic logic [DIG_W-1:0] digit_of(input logic [DATA_W-1:0] d,
                                                  input logic [IDX_W-1:0]  i);
        logic [DIG_W-1:0] n;
        n = d[3:0];
        case (i)
            2'd0:    n = d[3:0];
            2'd1:    n = d[7:4];
            2'd2:    n = d[11:8];
            default: n = d[15:12];
        endcase
        return n;
    endfunction

    // Digit is a leading zero: it and every more-significant digit are zero (digit0 never).
    function automatic logic lead_zero(input logic [DATA_W-1:0] d,
                                       input logic [IDX_W-1:0]  i);
        logic z;
        z = 1'b0;
        case (i)
            2'd0:    z = 1'b0;
            2'd1:    z = (d[15:4] == 12'h000);
            2'd2:    z = (d[15:8] == 8'h00);
            default: z = (d[15:12] == 4'h0);
        endcase
        return z;
    endfunction

    // Prescaler and digit index.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        idx_d  = idx_q;
        tick_c = (cnt_q == CNT_LAST);
        if (tick_c) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
        end
    end

    // Pending/display handoff; frame_done_q marks the current cycle as the frame boundary.
    always_comb begin
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        if (frame_done_q) begin
            if (load) begin
                disp_d = din;
            end else if (pend_q) begin
                disp_d = pend_data_q;
            end
            pend_d = 1'b0;
        end else if (load) begin
            pend_data_d = din;
            pend_d      = 1'b1;
        end
    end

    // Outputs are precomputed from next-state registers so they line up with idx/display.
    always_comb begin
        frame_done_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
        bcd_d        = digit_of(disp_d, idx_d);
        an_d         = ~(4'b0001 << idx_d);
        blank_d      = (bcd_d > DIG_W'(9));
        if (BLANK_LZ && lead_zero(disp_d, idx_d)) begin
            blank_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_data_q  <= '0;
            pend_q       <= 1'b0;
            frame_done_q <= 1'b0;
            bcd_q        <= '0;
            an_q         <= 4'b1110;
            blank_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_data_q  <= pend_data_d;
            pend_q       <= pend_d;
            frame_done_q <= frame_done_d;
            bcd_q        <= bcd_d;
            an_q         <= an_d;
            blank_q      <= blank_d;
        end
    end

    // The ack must coincide with a same-cycle boundary load, so it cannot be registered.
    assign load_ack   = frame_done_q & (load | pend_q);
    assign frame_done = frame_done_q;
    assign bcd        = bcd_q;
    assign an         = an_q;
    assign blank      = blank_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with TICK_DIV=4, BLANK_LZ=1.
// Cycle k is the clock period starting at the k-th rising edge after reset release (k=0 first).
module tb_seg_scan_mux;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] din;
    logic        load_ack;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        blank;
    logic        frame_done;

    int n_assert;
    int n_fail;
    int cyc;

    seg_scan_mux #(.TICK_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .din        (din),
        .load_ack   (load_ack),
        .bcd        (bcd),
        .an         (an),
        .blank      (blank),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Hold reset, check asynchronous reset values, release just after a rising edge.
    task automatic do_reset();
        load = 1'b0;
        din  = 16'h0000;
        rst  = 1'b1;
        #1;
        chk("rst_an",    16'(an),         16'h000E);
        chk("rst_bcd",   16'(bcd),        16'h0000);
        chk("rst_blank", 16'(blank),      16'h0000);
        chk("rst_ack",   16'(load_ack),   16'h0000);
        chk("rst_fd",    16'(frame_done), 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    // Check one cycle against the expected displayed word, then step into the next cycle.
    task automatic run_cycle(input logic [15:0] d, input logic exp_ack);
        logic [1:0]  ix;
        logic [3:0]  nib;
        logic [3:0]  exp_an;
        logic        exp_blank;
        logic [15:0] upper;
        ix     = 2'((cyc / 4) % 4);
        nib    = 4'(d >> (4 * ix));
        exp_an = ~(4'b0001 << ix);
        upper  = d >> (4 * ix);
        exp_blank = (nib > 4'd9) || ((ix != 2'd0) && (upper == 16'h0000));
        @(negedge clk);
        chk($sformatf("an_c%0d", cyc),    16'(an),         16'(exp_an));
        chk($sformatf("bcd_c%0d", cyc),   16'(bcd),        16'(nib));
        chk($sformatf("blank_c%0d", cyc), 16'(blank),      16'(exp_blank));
        chk($sformatf("fd_c%0d", cyc),    16'(frame_done), 16'((cyc % 16) == 15));
        chk($sformatf("ack_c%0d", cyc),   16'(load_ack),   16'(exp_ack));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int last, input logic [15:0] d);
        while (cyc <= last) run_cycle(d, 1'b0);
    endtask

    task automatic load_cycle(input logic [15:0] v, input logic [15:0] d, input logic exp_ack);
        load = 1'b1;
        din  = v;
        run_cycle(d, exp_ack);
        load = 1'b0;
        din  = 16'h0000;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b1;
        load     = 1'b0;
        din      = 16'h0000;

        // Idle scan: two full frames of zeros.
        do_reset();
        run_to(31, 16'h0000);

        // Single load mid-frame, committed at the frame boundary.
        do_reset();
        run_to(1, 16'h0000);
        load_cycle(16'h1234, 16'h0000, 1'b0);
        run_to(14, 16'h0000);
        run_cycle(16'h0000, 1'b1);
        run_to(31, 16'h1234);

        // Two loads in one frame: latest wins, single ack.
        do_reset();
        run_to(1, 16'h0000);
        load_cycle(16'h1111, 16'h0000, 1'b0);
        run_to(8, 16'h0000);
        load_cycle(16'h2222, 16'h0000, 1'b0);
        run_to(14, 16'h0000);
        run_cycle(16'h0000, 1'b1);
        run_to(31, 16'h2222);

        // Load exactly on the boundary cycle.
        do_reset();
        run_to(14, 16'h0000);
        load_cycle(16'h0050, 16'h0000, 1'b1);
        run_to(31, 16'h0050);

        // Invalid BCD nibble is blanked.
        do_reset();
        run_to(1, 16'h0000);
        load_cycle(16'h00A0, 16'h0000, 1'b0);
        run_to(14, 16'h0000);
        run_cycle(16'h0000, 1'b1);
        run_to(31, 16'h00A0);

        // Reset mid-frame discards the pending load.
        do_reset();
        run_to(4, 16'h0000);
        load_cycle(16'h1234, 16'h0000, 1'b0);
        run_to(8, 16'h0000);
        #2;
        chk("pre_rst_an",    16'(an),    16'h000B);
        chk("pre_rst_blank", 16'(blank), 16'h0001);
        rst = 1'b1;
        #1;
        chk("async_an",    16'(an),         16'h000E);
        chk("async_bcd",   16'(bcd),        16'h0000);
        chk("async_blank", 16'(blank),      16'h0000);
        chk("async_ack",   16'(load_ack),   16'h0000);
        chk("async_fd",    16'(frame_done), 16'h0000);
        do_reset();
        run_to(31, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
